block_allocator: RTL and testbench

First-fit contiguous block allocator with explicit free, the successor to the single-request allocator used alongside the `ebr` block memory. It keeps a per-block occupancy bitmap. It serves variable-size allocation requests by scanning one block per cycle, and releases ranges on free requests. It reports the remaining free-block count. It sits between packet/buffer producers and the `ebr` store, handing out block addresses for `ebr` read/write.

---
 rtl/block_allocator_if.sv | 28 ++
 rtl/block_allocator.sv | 139 +++++++++++++
 tb/tb_block_allocator.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/block_allocator_if.sv
// Request/response bundle between buffer producers and block_allocator.
// Producers drive the master modport; the allocator takes the slave modport.
interface block_allocator_if #(
  parameter int NUM_BLOCKS       = 32,
  parameter int NUM_BLOCKS_WIDTH = $clog2(NUM_BLOCKS)
);
  logic                        alloc_en;
  logic [NUM_BLOCKS_WIDTH:0]   request_size;
  logic                        free_en;
  logic [NUM_BLOCKS_WIDTH-1:0] free_addr;
  logic [NUM_BLOCKS_WIDTH:0]   free_size;
  logic [NUM_BLOCKS_WIDTH-1:0] o_addr;
  logic                        o_valid;
  logic                        o_err;
  logic                        o_busy;
  logic                        o_free_err;
  logic [NUM_BLOCKS_WIDTH:0]   o_free_count;

  modport master (
    output alloc_en, request_size, free_en, free_addr, free_size,
    input  o_addr, o_valid, o_err, o_busy, o_free_err, o_free_count
  );

  modport slave (
    input  alloc_en, request_size, free_en, free_addr, free_size,
    output o_addr, o_valid, o_err, o_busy, o_free_err, o_free_count
  );
endinterface

// File: rtl/block_allocator.sv
// First-fit contiguous block allocator over an occupancy bitmap; ALLOCATOR_FREE_CHECK_EN rejects frees touching free blocks.
// Latency: grant/err one cycle after the scan edge of the last block examined (1..NUM_BLOCKS cycles); frees land next edge.
// Backpressure: alloc_en ignored while o_busy; frees accepted every cycle, no stall.
module block_allocator #(
  parameter int NUM_BLOCKS       = 32,
  parameter int NUM_BLOCKS_WIDTH = $clog2(NUM_BLOCKS)
) (
  input logic              clk,
  input logic              rst,
  block_allocator_if.slave bus
);
  localparam int W  = NUM_BLOCKS_WIDTH;
  localparam int W1 = NUM_BLOCKS_WIDTH + 1;
  localparam int W2 = NUM_BLOCKS_WIDTH + 2;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                state, state_n;
  logic [NUM_BLOCKS-1:0] bitmap, bitmap_n;
  logic [W-1:0]          idx, idx_n;
  logic [W:0]            run, run_n;
  logic [W:0]            size, size_n;
  logic [W-1:0]          addr_q, addr_n;
  logic                  valid_q, valid_n;
  logic                  err_q, err_n;
  logic                  free_err_q, free_err_n;
  logic [W:0]            count_q, count_n;

  logic [W2-1:0]         free_end;
  logic [NUM_BLOCKS-1:0] free_mask;
  logic [NUM_BLOCKS-1:0] alloc_mask;
  logic                  free_ok;
  logic [W:0]            run_inc;
  logic [W-1:0]          start;
  logic [W:0]            used;

  // Range end is computed two bits wide of the address so it cannot wrap.
  always_comb begin
    free_end  = W2'(bus.free_addr) + W2'(bus.free_size);
    free_mask = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      free_mask[i] = (W2'(i) >= W2'(bus.free_addr)) && (W2'(i) < free_end);
    end
    free_ok = bus.free_en && (bus.free_size != '0) && (free_end <= W2'(NUM_BLOCKS));
`ifdef ALLOCATOR_FREE_CHECK_EN
    if ((free_mask & ~bitmap) != '0) begin
      free_ok = 1'b0;
    end
`endif
    free_err_n = bus.free_en && !free_ok;
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    run_n      = run;
    size_n     = size;
    addr_n     = addr_q;
    valid_n    = 1'b0;
    err_n      = 1'b0;
    alloc_mask = '0;
    run_inc    = run + W1'(1);
    start      = idx + W'(1) - size[W-1:0];
    case (state)
      IDLE: begin
        if (bus.alloc_en) begin
          if ((bus.request_size != '0) && (bus.request_size <= W1'(NUM_BLOCKS))) begin
            size_n  = bus.request_size;
            run_n   = '0;
            idx_n   = '0;
            state_n = SCAN;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      SCAN: begin
        if (!bitmap[idx] && (run_inc == size)) begin
          for (int i = 0; i < NUM_BLOCKS; i++) begin
            alloc_mask[i] = (W'(i) >= start) && (W'(i) <= idx);
          end
          addr_n  = start;
          valid_n = 1'b1;
          state_n = IDLE;
        end else if (idx == W'(NUM_BLOCKS - 1)) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          run_n = bitmap[idx] ? '0 : run_inc;
          idx_n = idx + W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Free clears first so a same-edge commit over the same bits keeps them used.
  always_comb begin
    bitmap_n = (bitmap & ~(free_ok ? free_mask : '0)) | alloc_mask;
    used     = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      used = used + W1'(bitmap_n[i]);
    end
    count_n = W1'(NUM_BLOCKS) - used;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bitmap     <= '0;
      idx        <= '0;
      run        <= '0;
      size       <= '0;
      addr_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      free_err_q <= 1'b0;
      count_q    <= W1'(NUM_BLOCKS);
    end else begin
      state      <= state_n;
      bitmap     <= bitmap_n;
      idx        <= idx_n;
      run        <= run_n;
      size       <= size_n;
      addr_q     <= addr_n;
      valid_q    <= valid_n;
      err_q      <= err_n;
      free_err_q <= free_err_n;
      count_q    <= count_n;
    end
  end

  assign bus.o_addr       = addr_q;
  assign bus.o_valid      = valid_q;
  assign bus.o_err        = err_q;
  assign bus.o_busy       = (state == SCAN);
  assign bus.o_free_err   = free_err_q;
  assign bus.o_free_count = count_q;
endmodule

// File: tb/tb_block_allocator.sv
// Directed bench for block_allocator with NUM_BLOCKS=8: cycle vector table plus multi-cycle sequences.
module tb_block_allocator;
  localparam int NB = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  block_allocator_if #(.NUM_BLOCKS(NB)) bus ();
  block_allocator #(.NUM_BLOCKS(NB)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic       rst;
    logic       alloc_en;
    logic [3:0] req;
    logic       free_en;
    logic [2:0] faddr;
    logic [3:0] fsize;
    logic       valid;
    logic       err;
    logic       busy;
    logic       ferr;
    logic       chk_addr;
    logic [2:0] addr;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic ae, input logic [3:0] rq,
                     input logic fe, input logic [2:0] fa, input logic [3:0] fs,
                     input logic v, input logic e, input logic b, input logic fr,
                     input logic ca, input logic [2:0] a, input logic [3:0] c);
    vec_t x;
    x.rst = r; x.alloc_en = ae; x.req = rq; x.free_en = fe; x.faddr = fa; x.fsize = fs;
    x.valid = v; x.err = e; x.busy = b; x.ferr = fr; x.chk_addr = ca; x.addr = a; x.cnt = c;
    tbl.push_back(x);
  endtask

  task automatic idle(input int n, input logic b, input logic [3:0] c);
    for (int i = 0; i < n; i++) add(0, 0, 0, 0, 0, 0, 0, 0, b, 0, 0, 0, c);
  endtask

  task automatic drive(input logic r, input logic ae, input logic [3:0] rq,
                       input logic fe, input logic [2:0] fa, input logic [3:0] fs);
    rst = r; bus.alloc_en = ae; bus.request_size = rq;
    bus.free_en = fe; bus.free_addr = fa; bus.free_size = fs;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] ok;
    drive(1, 0, 0, 0, 0, 0);

    // Reset, alloc 3 -> addr 0 after E3.
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8);
    add(0, 1, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 8);
    idle(2, 1, 8);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 5);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5);
    // Alloc 2 -> addr 3; free 0/3; alloc 2 -> addr 0.
    add(0, 1, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5);
    idle(4, 1, 5);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 3, 3);
    add(0, 0, 0, 1, 0, 3, 0, 0, 0, 0, 1, 3, 6);
    add(0, 1, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6);
    idle(1, 1, 6);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 4);
    // Reset, alloc 8 -> addr 0; alloc 1 -> no fit at E8; illegal sizes.
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8);
    add(0, 1, 8, 0, 0, 0, 0, 0, 1, 0, 0, 0, 8);
    idle(7, 1, 8);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(7, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 9, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    idle(1, 0, 0);
    // Free range errors, exact-end free, then free of an already free block 7.
    add(0, 0, 0, 1, 6, 3, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 5, 3, 0, 0, 0, 0, 0, 0, 3);
`ifdef ALLOCATOR_FREE_CHECK_EN
    add(0, 0, 0, 1, 7, 1, 0, 0, 0, 1, 0, 0, 3);
`else
    add(0, 0, 0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 3);
`endif
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3);

    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].alloc_en, tbl[k].req, tbl[k].free_en, tbl[k].faddr, tbl[k].fsize);
      tick();
      check($sformatf("vec%0d_flags_cnt", k),
            {bus.o_valid, bus.o_err, bus.o_busy, bus.o_free_err, bus.o_free_count},
            {tbl[k].valid, tbl[k].err, tbl[k].busy, tbl[k].ferr, tbl[k].cnt});
      if (tbl[k].chk_addr) check($sformatf("vec%0d_addr", k), bus.o_addr, tbl[k].addr);
    end

    // Fragmentation: blocks 0,2,4,6 used.
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 8, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0); repeat (8) tick();
    check("frag_fill_cnt", bus.o_free_count, 0);
    for (int b = 1; b < NB; b += 2) begin
      drive(0, 0, 0, 1, 3'(b), 1); tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    check("frag_cnt", bus.o_free_count, 4);
    drive(0, 1, 2, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0); repeat (7) tick();
    check("frag_busy_e7", bus.o_busy, 1);
    tick();
    check("frag_err_e8", {bus.o_err, bus.o_busy, bus.o_valid}, 3'b100);
    drive(0, 0, 0, 1, 2, 1); tick();
    check("frag_free2_cnt", bus.o_free_count, 5);
    drive(0, 1, 3, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0); repeat (3) tick();
    check("frag_no_grant_e3", bus.o_valid, 0);
    tick();
    check("frag_grant_e4", {bus.o_valid, bus.o_busy}, 2'b10);
    check("frag_addr", bus.o_addr, 1);
    check("frag_grant_cnt", bus.o_free_count, 2);

    // Free during scan: used 3,4,5; free 4/2 while index is 1; alloc 4 -> addr 4 at E8.
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 8, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0); repeat (8) tick();
    drive(0, 0, 0, 1, 0, 3); tick();
    drive(0, 0, 0, 1, 6, 2); tick();
    check("scanfree_pre_cnt", bus.o_free_count, 5);
    drive(0, 1, 4, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 4, 2); tick();
    check("scanfree_mid", {bus.o_busy, bus.o_free_err, bus.o_free_count}, {2'b10, 4'd7});
    drive(0, 0, 0, 0, 0, 0); repeat (5) tick();
    check("scanfree_no_grant_e7", bus.o_valid, 0);
    tick();
    check("scanfree_grant_e8", {bus.o_valid, bus.o_busy, 1'b0, bus.o_addr}, {3'b100, 3'd4});
    check("scanfree_cnt", bus.o_free_count, 3);

    // Reset mid-scan: no grant, bitmap cleared.
    drive(0, 1, 2, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0); tick();
    check("rst_mid", {bus.o_valid, bus.o_busy, bus.o_err, bus.o_free_count}, {3'b000, 4'd8});
    drive(0, 0, 0, 0, 0, 0);
    ok = 8'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      ok = ok | {7'd0, bus.o_valid};
    end
    check("rst_no_late_grant", ok, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
